mc_ctrl: RTL and testbench

//  Multicycle main controller for the MIPS core. Decodes opcode/funct, sequences

---
 rtl/mc_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle main controller for the MIPS core.
// Decodes opcode/funct, sequences FETCH through write-back, and drives alu_op,
// the datapath mux selects and the write enables. Runs a req/ack handshake to
// unified memory and guards it with a bus-timeout watchdog.
// Ports:
//   clk, rst_n (async active-low)    opcode/funct (IR fields)   alu_zero, mem_ack
//   mem_req/mem_we/iord              ir_we/pc_we/pc_src         alu_op/alu_srca/alu_srcb
//   reg_we/reg_dst/wb_sel            bus_err (sticky)           exc (trap pulse), state (debug)
// Build option: MC_CTRL_ILLEGAL_TRAP_EN routes illegal instructions to TRAP;
// without it they retire as a NOP and exc stays 0.
//
// state    | meaning
// RST      | one cycle after reset, outputs idle
// FETCH    | read instruction at PC, PC += 4 on ack
// DECODE   | branch target -> ALUOut, dispatch on opcode/funct
// EXEC_R   | R-type ALU operation
// EXEC_I   | immediate ALU operation
// MEM_ADDR | effective address for lw/sw
// MEM_RD   | data read, wait for ack
// MEM_WR   | data write, wait for ack
// WB_R     | write rd from ALUOut
// WB_I     | write rt from ALUOut
// WB_MEM   | write rt from MDR
// BRANCH   | compare rs/rt, conditionally load branch target
// JUMP     | load jump target (jal also writes r31)
// JR       | load PC from rs
// TRAP     | load exception vector
// HALT     | bus timeout, only reset leaves
module mc_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic       bus_err,
  output logic       exc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WR = 4'd7,
    S_WB_R = 4'd8, S_WB_I = 4'd9, S_WB_MEM = 4'd10, S_BRANCH = 4'd11,
    S_JUMP = 4'd12, S_JR = 4'd13, S_TRAP = 4'd14, S_HALT = 4'd15
  } state_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] FN_JR = 6'b001000;

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t st, st_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic r_legal, i_legal, wd_last;

  always_comb begin
    r_legal = 1'b0;
    case (funct)
      6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
      6'b001000, 6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
      6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011: r_legal = 1'b1;
      default: r_legal = 1'b0;
    endcase
  end

  // addi..xori occupy 001000..001110; 001111 (lui) is not supported
  assign i_legal = (opcode[5:3] == 3'b001) && (opcode[2:0] != 3'b111);
  assign wd_last = (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= S_RST;
      wd_cnt <= '0;
    end else begin
      st <= st_nxt;
      // only counts while a request is waiting in the same state
      if (mem_req && !mem_ack && (st_nxt == st))
        wd_cnt <= wd_cnt + 1'b1;
      else
        wd_cnt <= '0;
    end
  end

  always_comb begin
    st_nxt   = st;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 2'b00;
    alu_op   = 4'b0000;
    alu_srca = 1'b0;
    alu_srcb = 2'b00;
    reg_we   = 1'b0;
    reg_dst  = 2'b00;
    wb_sel   = 2'b00;
    exc      = 1'b0;
    case (st)
      S_RST: st_nxt = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        alu_srcb = 2'b01;
        if (mem_ack) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          st_nxt = S_DECODE;
        end else if (wd_last) begin
          st_nxt = S_HALT;
        end
      end
      S_DECODE: begin
        alu_srcb = 2'b10;
        if (opcode == OP_R) begin
          if (funct == FN_JR)
            st_nxt = S_JR;
          else if (r_legal)
            st_nxt = S_EXEC_R;
          else
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            st_nxt = S_TRAP;
`else
            st_nxt = S_FETCH;
`endif
        end else if (opcode == OP_LW || opcode == OP_SW)
          st_nxt = S_MEM_ADDR;
        else if (opcode == OP_BEQ || opcode == OP_BNE)
          st_nxt = S_BRANCH;
        else if (opcode == OP_J || opcode == OP_JAL)
          st_nxt = S_JUMP;
        else if (i_legal)
          st_nxt = S_EXEC_I;
        else
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          st_nxt = S_TRAP;
`else
          st_nxt = S_FETCH;
`endif
      end
      S_EXEC_R: begin
        alu_srca = 1'b1;
        alu_op   = 4'b1111;
        st_nxt   = S_WB_R;
      end
      S_EXEC_I: begin
        alu_srca = 1'b1;
        case (opcode)
          OP_ANDI:  begin alu_op = 4'b0010; alu_srcb = 2'b11; end
          OP_ORI:   begin alu_op = 4'b0011; alu_srcb = 2'b11; end
          OP_XORI:  begin alu_op = 4'b0101; alu_srcb = 2'b11; end
          OP_SLTI:  begin alu_op = 4'b0110; alu_srcb = 2'b10; end
          OP_SLTIU: begin alu_op = 4'b0111; alu_srcb = 2'b10; end
          default:  begin alu_op = 4'b0000; alu_srcb = 2'b10; end
        endcase
        st_nxt = S_WB_I;
      end
      S_MEM_ADDR: begin
        alu_srca = 1'b1;
        alu_srcb = 2'b10;
        st_nxt   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ack)      st_nxt = S_WB_MEM;
        else if (wd_last) st_nxt = S_HALT;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ack)      st_nxt = S_FETCH;
        else if (wd_last) st_nxt = S_HALT;
      end
      S_WB_R: begin
        reg_we  = 1'b1;
        reg_dst = 2'b01;
        st_nxt  = S_FETCH;
      end
      S_WB_I: begin
        reg_we = 1'b1;
        st_nxt = S_FETCH;
      end
      S_WB_MEM: begin
        reg_we = 1'b1;
        wb_sel = 2'b01;
        st_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_srca = 1'b1;
        alu_op   = 4'b0001;
        pc_src   = 2'b01;
        pc_we    = (opcode == OP_BNE) ? !alu_zero : alu_zero;
        st_nxt   = S_FETCH;
      end
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_src = 2'b10;
        if (opcode == OP_JAL) begin
          reg_we  = 1'b1;
          reg_dst = 2'b10;
          wb_sel  = 2'b10;
        end
        st_nxt = S_FETCH;
      end
      S_JR: begin
        pc_we  = 1'b1;
        pc_src = 2'b11;
        st_nxt = S_FETCH;
      end
      S_TRAP: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        exc   = 1'b1;
        pc_we = 1'b1;
`endif
        st_nxt = S_FETCH;
      end
      S_HALT: st_nxt = S_HALT;
      default: st_nxt = S_RST;
    endcase
  end

  // HALT is entered only on timeout and left only by reset, so it is the sticky flag
  assign bus_err = (st == S_HALT);
  assign state   = st;

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

  logic       clk, rst_n;
  logic [5:0] opcode, funct;
  logic       alu_zero, mem_ack;
  logic       mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0] pc_src;
  logic [3:0] alu_op;
  logic       alu_srca;
  logic [1:0] alu_srcb;
  logic       reg_we;
  logic [1:0] reg_dst, wb_sel;
  logic       bus_err, exc;
  logic [3:0] state;

  mc_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .reg_we(reg_we), .reg_dst(reg_dst),
    .wb_sel(wb_sel), .bus_err(bus_err), .exc(exc), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [24:0] obs;
  assign obs = {state, mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_op,
                alu_srca, alu_srcb, reg_we, reg_dst, wb_sel, bus_err, exc};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        ack;
    logic        zero;
    logic [24:0] exp;
  } cyc_t;

  cyc_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [24:0] ev(
    input logic [3:0] s, input logic req, input logic we, input logic io,
    input logic irw, input logic pcw, input logic [1:0] pcs, input logic [3:0] aop,
    input logic sa, input logic [1:0] sbv, input logic rw, input logic [1:0] rd,
    input logic [1:0] ws, input logic be, input logic ex);
    return {s, req, we, io, irw, pcw, pcs, aop, sa, sbv, rw, rd, ws, be, ex};
  endfunction

  function automatic logic [24:0] e_fetch(input logic ack);
    return ev(4'd1, 1, 0, 0, ack, ack, 2'b00, 4'b0000, 0, 2'b01, 0, 2'b00, 2'b00, 0, 0);
  endfunction

  function automatic logic [24:0] e_dec();
    return ev(4'd2, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 2'b10, 0, 2'b00, 2'b00, 0, 0);
  endfunction

  function automatic logic [24:0] e_maddr();
    return ev(4'd5, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 1, 2'b10, 0, 2'b00, 2'b00, 0, 0);
  endfunction

  function automatic logic [24:0] e_memrd();
    return ev(4'd6, 1, 0, 1, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0);
  endfunction

  function automatic logic [24:0] e_wbmem();
    return ev(4'd10, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 1, 2'b00, 2'b01, 0, 0);
  endfunction

  task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic ack,
                      input logic zero, input logic [24:0] exp);
    cyc_t c;
    c.op = op; c.fn = fn; c.ack = ack; c.zero = zero; c.exp = exp;
    sb.push_back(c);
  endtask

  // drives one cycle (called just after a rising edge) and returns mid-cycle outputs
  task automatic step(input cyc_t c, output logic [24:0] o);
    opcode = c.op; funct = c.fn; mem_ack = c.ack; alu_zero = c.zero;
    @(negedge clk);
    o = obs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc_t c;
    logic [24:0] o;
    int n = 0;
    mem_ack = 1'b1;
    #1;
    checks++;
    if (obs !== 25'h0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", obs, 25'h0);
    end
    rst_n = 1'b1;
    push(6'h00, 6'h00, 0, 0, 25'h0);
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); checks++;
      if (o !== c.exp) begin failures++; $display("FAIL reset cyc%0d got=%h exp=%h", n, o, c.exp); end
      n++;
    end
  endtask

  task automatic test_add();
    cyc_t c;
    logic [24:0] o;
    int n = 0;
    push(6'b000000, 6'b100000, 1, 0, e_fetch(1));
    push(6'b000000, 6'b100000, 0, 0, e_dec());
    push(6'b000000, 6'b100000, 0, 0, ev(4'd3, 0, 0, 0, 0, 0, 2'b00, 4'b1111, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    push(6'b000000, 6'b100000, 0, 0, ev(4'd8, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 1, 2'b01, 2'b00, 0, 0));
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); checks++;
      if (o !== c.exp) begin failures++; $display("FAIL add cyc%0d got=%h exp=%h", n, o, c.exp); end
      n++;
    end
  endtask

  task automatic test_imm();
    cyc_t c;
    logic [24:0] o;
    int n = 0;
    logic [5:0] ops [6] = '{6'b001101, 6'b001100, 6'b001110, 6'b001010, 6'b001011, 6'b001001};
    logic [3:0] aops [6] = '{4'b0011, 4'b0010, 4'b0101, 4'b0110, 4'b0111, 4'b0000};
    logic [1:0] srcbs [6] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10};
    for (int i = 0; i < 6; i++) begin
      push(ops[i], 6'h00, 1, 0, e_fetch(1));
      push(ops[i], 6'h00, 0, 0, e_dec());
      push(ops[i], 6'h00, 0, 0, ev(4'd4, 0, 0, 0, 0, 0, 2'b00, aops[i], 1, srcbs[i], 0, 2'b00, 2'b00, 0, 0));
      push(ops[i], 6'h00, 0, 0, ev(4'd9, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 1, 2'b00, 2'b00, 0, 0));
    end
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); checks++;
      if (o !== c.exp) begin failures++; $display("FAIL imm cyc%0d got=%h exp=%h", n, o, c.exp); end
      n++;
    end
  endtask

  task automatic test_lw_wait();
    cyc_t c;
    logic [24:0] o;
    int n = 0;
    push(6'b100011, 6'h00, 1, 0, e_fetch(1));
    push(6'b100011, 6'h00, 0, 0, e_dec());
    push(6'b100011, 6'h00, 0, 0, e_maddr());
    for (int i = 0; i < 3; i++) push(6'b100011, 6'h00, 0, 0, e_memrd());
    push(6'b100011, 6'h00, 1, 0, e_memrd());
    push(6'b100011, 6'h00, 0, 0, e_wbmem());
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); checks++;
      if (o !== c.exp) begin failures++; $display("FAIL lw_wait cyc%0d got=%h exp=%h", n, o, c.exp); end
      n++;
    end
  endtask

  task automatic test_sw();
    cyc_t c;
    logic [24:0] o;
    int n = 0;
    push(6'b101011, 6'h00, 1, 0, e_fetch(1));
    push(6'b101011, 6'h00, 0, 0, e_dec());
    push(6'b101011, 6'h00, 0, 0, e_maddr());
    push(6'b101011, 6'h00, 1, 0, ev(4'd7, 1, 1, 1, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); checks++;
      if (o !== c.exp) begin failures++; $display("FAIL sw cyc%0d got=%h exp=%h", n, o, c.exp); end
      n++;
    end
  endtask

  task automatic test_branch();
    cyc_t c;
    logic [24:0] o;
    int n = 0;
    logic [5:0] ops [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
    logic zs [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic taken [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      push(ops[i], 6'h00, 1, zs[i], e_fetch(1));
      push(ops[i], 6'h00, 0, zs[i], e_dec());
      push(ops[i], 6'h00, 0, zs[i], ev(4'd11, 0, 0, 0, 0, taken[i], 2'b01, 4'b0001, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    end
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); checks++;
      if (o !== c.exp) begin failures++; $display("FAIL branch cyc%0d got=%h exp=%h", n, o, c.exp); end
      n++;
    end
  endtask

  task automatic test_jump();
    cyc_t c;
    logic [24:0] o;
    int n = 0;
    push(6'b000011, 6'h00, 1, 0, e_fetch(1));
    push(6'b000011, 6'h00, 0, 0, e_dec());
    push(6'b000011, 6'h00, 0, 0, ev(4'd12, 0, 0, 0, 0, 1, 2'b10, 4'b0000, 0, 2'b00, 1, 2'b10, 2'b10, 0, 0));
    push(6'b000010, 6'h00, 1, 0, e_fetch(1));
    push(6'b000010, 6'h00, 0, 0, e_dec());
    push(6'b000010, 6'h00, 0, 0, ev(4'd12, 0, 0, 0, 0, 1, 2'b10, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    push(6'b000000, 6'b001000, 1, 0, e_fetch(1));
    push(6'b000000, 6'b001000, 0, 0, e_dec());
    push(6'b000000, 6'b001000, 0, 0, ev(4'd13, 0, 0, 0, 0, 1, 2'b11, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); checks++;
      if (o !== c.exp) begin failures++; $display("FAIL jump cyc%0d got=%h exp=%h", n, o, c.exp); end
      n++;
    end
  endtask

  task automatic test_illegal();
    cyc_t c;
    logic [24:0] o;
    int n = 0;
    logic [5:0] ops [3] = '{6'b111111, 6'b000000, 6'b001111};
    logic [5:0] fns [3] = '{6'b000000, 6'b000001, 6'b000000};
    for (int i = 0; i < 3; i++) begin
      push(ops[i], fns[i], 1, 0, e_fetch(1));
      push(ops[i], fns[i], 0, 0, e_dec());
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      push(ops[i], fns[i], 0, 0, ev(4'd14, 0, 0, 0, 0, 1, 2'b00, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1));
`endif
    end
    // the next instruction must start with a fetch
    push(6'b000000, 6'b100000, 0, 0, e_fetch(0));
    push(6'b000000, 6'b100000, 1, 0, e_fetch(1));
    push(6'b000000, 6'b100000, 0, 0, e_dec());
    push(6'b000000, 6'b100000, 0, 0, ev(4'd3, 0, 0, 0, 0, 0, 2'b00, 4'b1111, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    push(6'b000000, 6'b100000, 0, 0, ev(4'd8, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 1, 2'b01, 2'b00, 0, 0));
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); checks++;
      if (o !== c.exp) begin failures++; $display("FAIL illegal cyc%0d got=%h exp=%h", n, o, c.exp); end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c;
    logic [24:0] o;
    int n = 0;
    push(6'b001000, 6'h00, 1, 0, e_fetch(1));
    push(6'b001000, 6'h00, 0, 0, e_dec());
    push(6'b001000, 6'h00, 0, 0, ev(4'd4, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 1, 2'b10, 0, 2'b00, 2'b00, 0, 0));
    push(6'b001000, 6'h00, 0, 0, ev(4'd9, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 1, 2'b00, 2'b00, 0, 0));
    push(6'b000101, 6'h00, 0, 0, e_fetch(0));
    push(6'b000101, 6'h00, 1, 0, e_fetch(1));
    push(6'b000101, 6'h00, 0, 0, e_dec());
    push(6'b000101, 6'h00, 0, 0, ev(4'd11, 0, 0, 0, 0, 1, 2'b01, 4'b0001, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    push(6'b100011, 6'h00, 1, 0, e_fetch(1));
    push(6'b100011, 6'h00, 0, 0, e_dec());
    push(6'b100011, 6'h00, 0, 0, e_maddr());
    push(6'b100011, 6'h00, 1, 0, e_memrd());
    push(6'b100011, 6'h00, 0, 0, e_wbmem());
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); checks++;
      if (o !== c.exp) begin failures++; $display("FAIL b2b cyc%0d got=%h exp=%h", n, o, c.exp); end
      n++;
    end
  endtask

  // ack on the sixteenth waiting cycle must still be accepted
  task automatic test_timeout_boundary();
    cyc_t c;
    logic [24:0] o;
    int n = 0;
    for (int i = 0; i < 15; i++) push(6'b000010, 6'h00, 0, 0, e_fetch(0));
    push(6'b000010, 6'h00, 1, 0, e_fetch(1));
    push(6'b000010, 6'h00, 0, 0, e_dec());
    push(6'b000010, 6'h00, 0, 0, ev(4'd12, 0, 0, 0, 0, 1, 2'b10, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); checks++;
      if (o !== c.exp) begin failures++; $display("FAIL to_edge cyc%0d got=%h exp=%h", n, o, c.exp); end
      n++;
    end
  endtask

  task automatic test_mid_reset();
    cyc_t c;
    logic [24:0] o;
    int n = 0;
    push(6'b100011, 6'h00, 1, 0, e_fetch(1));
    push(6'b100011, 6'h00, 0, 0, e_dec());
    push(6'b100011, 6'h00, 0, 0, e_maddr());
    push(6'b100011, 6'h00, 0, 0, e_memrd());
    push(6'b100011, 6'h00, 0, 0, e_memrd());
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); checks++;
      if (o !== c.exp) begin failures++; $display("FAIL mid_rst cyc%0d got=%h exp=%h", n, o, c.exp); end
      n++;
    end
    // still in MEM_RD here; reset must abort without waiting for a clock
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 25'h0) begin
      failures++;
      $display("FAIL mid_rst_async got=%h exp=%h", obs, 25'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(6'b100011, 6'h00, 0, 0, 25'h0);
    push(6'b100011, 6'h00, 1, 0, e_fetch(1));
    push(6'b100011, 6'h00, 0, 0, e_dec());
    push(6'b100011, 6'h00, 0, 0, e_maddr());
    push(6'b100011, 6'h00, 1, 0, e_memrd());
    push(6'b100011, 6'h00, 0, 0, e_wbmem());
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); checks++;
      if (o !== c.exp) begin failures++; $display("FAIL post_rst cyc%0d got=%h exp=%h", n, o, c.exp); end
      n++;
    end
  endtask

  task automatic test_timeout();
    cyc_t c;
    logic [24:0] o;
    int n = 0;
    for (int i = 0; i < 16; i++) push(6'b000000, 6'b100000, 0, 0, e_fetch(0));
    for (int i = 0; i < 3; i++)
      push(6'b000000, 6'b100000, 1, 0, ev(4'd15, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0));
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); checks++;
      if (o !== c.exp) begin failures++; $display("FAIL timeout cyc%0d got=%h exp=%h", n, o, c.exp); end
      n++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_err !== 1'b0 || state !== 4'd0) begin
      failures++;
      $display("FAIL timeout_clear got bus_err=%b state=%0d exp bus_err=0 state=0", bus_err, state);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(6'b000000, 6'b100000, 0, 0, 25'h0);
    push(6'b000000, 6'b100000, 1, 0, e_fetch(1));
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); checks++;
      if (o !== c.exp) begin failures++; $display("FAIL timeout_rec cyc%0d got=%h exp=%h", n, o, c.exp); end
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 6'h00;
    funct = 6'h00;
    alu_zero = 1'b0;
    mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_add();
    test_imm();
    test_lw_wait();
    test_sw();
    test_branch();
    test_jump();
    test_illegal();
    test_back_to_back();
    test_timeout_boundary();
    test_mid_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
